uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive FIFO for the 16550-style UART, directly downstream of the serial receiver. It captures each byte delivered on the receiver's `o_data`/`o_flag` pair and buffers up to DEPTH bytes for the host-side register interface. It reports fill level, a programmable trigger-level flag, a sticky overrun flag and an optional character-timeout indication, matching 16550 RX FIFO semantics.

## Interface
- `DEPTH`, 16: number of byte entries; must be a power of two, ≥ 4.
- `AW`, 4: pointer width, log2(DEPTH).
- `TO_CYCLES`, 208320: timeout threshold in `i_sys_clk` cycles (4 characters × 10 bits × 5208 clk/bit at 9600 baud, 50 MHz).
- `i_sys_clk` input 1: system clock; all logic is on the rising edge.
- `i_sys_rst_n` input 1: asynchronous, active-low reset.
- `i_wr_data` input 8: received byte; connect to the receiver's `o_data`.
- `i_wr_flag` input 1: one-cycle write strobe; connect to the receiver's `o_flag`.
- `i_rd_en` input 1: one-cycle pop strobe from the host register read.
- `i_fifo_clr` input 1: synchronous clear (FCR bit 1).
- `i_ovr_clr` input 1: clears `o_overrun` (LSR read).
- `i_trig_lvl` input 2: trigger level select; 0→1, 1→4, 2→8, 3→14 bytes.
- `o_rd_data` output 8: head-of-queue byte (first-word fall-through).
- `o_count` output AW+1: number of stored bytes, 0..DEPTH.
- `o_empty` output 1: `o_count` == 0.
- `o_full` output 1: `o_count` == DEPTH.
- `o_trig` output 1: `o_count` ≥ selected trigger level.
- `o_overrun` output 1: sticky; a write was dropped because the FIFO was full.
- `o_timeout` output 1: character-timeout indication.

## Operation
- Storage: DEPTH×8 register array with AW-bit write and read pointers that wrap naturally modulo DEPTH, plus an (AW+1)-bit occupancy counter.
- Write: accepted when `i_wr_flag`=1 and the FIFO is not full (or is full with a simultaneous accepted read). On acceptance the byte goes to `mem[wr_ptr]` and `wr_ptr` increments.
- Read: accepted when `i_rd_en`=1 and `o_empty`=0. On acceptance `rd_ptr` increments. A read while empty is ignored and leaves no state change.
- Write and read in the same cycle:
  - Not empty: both are performed and `o_count` is unchanged.
  - Empty: only the write is performed and `o_count` becomes 1.
  - Full: both are performed, `o_count` stays DEPTH, and `o_overrun` is not set.
- Overflow: `i_wr_flag`=1 while full with no accepted read drops the byte, leaves the pointers unchanged, and sets `o_overrun`. `o_overrun` clears on `i_ovr_clr`; if set and clear occur in the same cycle, set wins.
- Clear: `i_fifo_clr` has priority over everything else. Pointers and count go to 0 on the next edge, and a same-cycle write or read is discarded. `o_overrun` is unaffected.
- `o_rd_data` = `mem[rd_ptr]` (combinational from registered pointer). It is undefined-but-stable while empty and must not be consumed when `o_empty`=1.
- `o_trig` is combinational from `o_count` and `i_trig_lvl`. Changing `i_trig_lvl` takes effect in the same cycle.
- Reset values:
  - `o_count`=0, `o_empty`=1, `o_full`=0, `o_trig`=0, `o_overrun`=0, `o_timeout`=0.
  - Pointers=0. Memory contents are not reset; `o_rd_data` is don't-care while empty.
- Reset asserted mid-operation discards all contents immediately (asynchronously).

## Timing
- Write latency: the byte strobed in cycle N is visible on `o_rd_data`, with `o_empty`=0 and `o_count` updated, in cycle N+1.
- Read latency: after a pop in cycle N, the next byte (or the `o_empty`=1 state) appears in cycle N+1.
- Back-to-back writes and reads on every cycle are supported at full throughput.
- `o_overrun` rises in the cycle after the dropped write.
- Receiver strobes are at least BAUD_CNT_MAX cycles apart, but the FIFO must not rely on this spacing.

## Configuration
- Macro `UART_RX_FIFO_TIMEOUT_EN`.
- Defined: a timeout counter of width ⌈log2 TO_CYCLES⌉ resets to 0 on any accepted write, accepted read, `i_fifo_clr`, or while empty.
  - Otherwise the counter increments and saturates at TO_CYCLES−1.
  - `o_timeout`=1 while the counter equals TO_CYCLES−1 and the FIFO is non-empty. It drops in the cycle after the next counter-resetting event.
- Undefined: no counter is built and `o_timeout` is tied to 0.

## Test plan
- Reset, write 0xA5 then 0x3C, read twice → `o_rd_data` is 0xA5 then 0x3C; `o_count` goes 1, 2, 1, 0; `o_empty`=1 at the end.
- 17 writes (0x00..0x10) with no reads → `o_full`=1 after the 16th, `o_overrun`=1 after the 17th, 16 reads return 0x00..0x0F, then `i_ovr_clr` → `o_overrun`=0.
- `i_trig_lvl`=2, write 7 bytes → `o_trig`=0; write the 8th → `o_trig`=1; switch to `i_trig_lvl`=3 → `o_trig`=0 in the same cycle.
- Full FIFO with simultaneous write 0x77 and read → `o_count` stays 16, no overrun, and 0x77 is read out last. Empty FIFO with simultaneous write and read → `o_count`=1.
- 5 bytes stored, `i_fifo_clr` together with `i_wr_flag` → next cycle `o_count`=0, `o_empty`=1. Also assert `i_sys_rst_n`=0 mid-burst → all outputs return to reset values.
- With `UART_RX_FIFO_TIMEOUT_EN` and TO_CYCLES=100, write 1 byte and stay idle → `o_timeout`=1 at the 99th cycle after the write; one read → `o_timeout`=0. Without the macro → `o_timeout` stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the 16550-style UART: first-word fall-through byte queue with
// trigger level, sticky overrun and optional character timeout (UART_RX_FIFO_TIMEOUT_EN).
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TO_CYCLES = 208320
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_rst_n,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_flag,
  input  logic          i_rd_en,
  input  logic          i_fifo_clr,
  input  logic          i_ovr_clr,
  input  logic [1:0]    i_trig_lvl,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_trig,
  output logic          o_overrun,
  output logic          o_timeout
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          overrun_reg;
  logic          wr_accept;
  logic          rd_accept;
  logic          ovr_set;
  logic [4:0]    trig_thr;

  assign o_empty = (count_reg == '0);
  assign o_full  = (count_reg == CNT_MAX);

  // Clear beats everything; a write into a full FIFO only lands if a read frees a slot.
  assign rd_accept = i_rd_en && !o_empty && !i_fifo_clr;
  assign wr_accept = i_wr_flag && (!o_full || rd_accept) && !i_fifo_clr;
  assign ovr_set   = i_wr_flag && o_full && !rd_accept && !i_fifo_clr;

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + CNT_ONE;
    end else if (!wr_accept && rd_accept) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (i_fifo_clr) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr_accept) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (rd_accept) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        count_reg <= count_next;
      end
      if (ovr_set) begin
        overrun_reg <= 1'b1;
      end else if (i_ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge i_sys_clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= i_wr_data;
  end

  assign o_rd_data = mem[rd_ptr_reg];
  assign o_count   = count_reg;
  assign o_overrun = overrun_reg;

  always_comb begin
    trig_thr = 5'd1;
    case (i_trig_lvl)
      2'd0: trig_thr = 5'd1;
      2'd1: trig_thr = 5'd4;
      2'd2: trig_thr = 5'd8;
      2'd3: trig_thr = 5'd14;
      default: trig_thr = 5'd1;
    endcase
  end

  assign o_trig = (32'(count_reg) >= 32'(trig_thr));

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int            TW     = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE = TW'(1);

  logic [TW-1:0] to_cnt_reg;

  // Counts idle cycles with data waiting; any FIFO activity restarts it.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      to_cnt_reg <= '0;
    end else if (wr_accept || rd_accept || i_fifo_clr || o_empty) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_reg <= to_cnt_reg + TO_ONE;
    end
  end

  assign o_timeout = (to_cnt_reg == TO_MAX) && !o_empty;
`else
  // Constant 0; TO_CYCLES only matters when the timeout counter is built.
  assign o_timeout = (TO_CYCLES < 0) & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (TO_CYCLES overridden to 100);
// timeout checks follow UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int TO_CYCLES = 100;

  logic          i_sys_clk = 1'b0;
  logic          i_sys_rst_n;
  logic [7:0]    i_wr_data;
  logic          i_wr_flag;
  logic          i_rd_en;
  logic          i_fifo_clr;
  logic          i_ovr_clr;
  logic [1:0]    i_trig_lvl;
  logic [7:0]    o_rd_data;
  logic [AW:0]   o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_trig;
  logic          o_overrun;
  logic          o_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TO_CYCLES(TO_CYCLES)) dut (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .i_wr_data   (i_wr_data),
    .i_wr_flag   (i_wr_flag),
    .i_rd_en     (i_rd_en),
    .i_fifo_clr  (i_fifo_clr),
    .i_ovr_clr   (i_ovr_clr),
    .i_trig_lvl  (i_trig_lvl),
    .o_rd_data   (o_rd_data),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_trig      (o_trig),
    .o_overrun   (o_overrun),
    .o_timeout   (o_timeout)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle();
    @(posedge i_sys_clk);
    @(negedge i_sys_clk);
  endtask

  task automatic push(input logic [7:0] b);
    i_wr_data = b;
    i_wr_flag = 1'b1;
    cycle();
    i_wr_flag = 1'b0;
    $display("[TB] push 0x%02h -> count=%0d", b, o_count);
  endtask

  task automatic pop();
    i_rd_en = 1'b1;
    cycle();
    i_rd_en = 1'b0;
    $display("[TB] pop -> count=%0d empty=%0b", o_count, o_empty);
  endtask

  task automatic pulse_clr();
    i_fifo_clr = 1'b1;
    cycle();
    i_fifo_clr = 1'b0;
  endtask

  initial begin
    i_sys_rst_n = 1'b0;
    i_wr_data   = 8'h00;
    i_wr_flag   = 1'b0;
    i_rd_en     = 1'b0;
    i_fifo_clr  = 1'b0;
    i_ovr_clr   = 1'b0;
    i_trig_lvl  = 2'd0;
    cycle();
    cycle();
    check("rst_count",   32'(o_count),   32'd0);
    check("rst_empty",   32'(o_empty),   32'd1);
    check("rst_full",    32'(o_full),    32'd0);
    check("rst_trig",    32'(o_trig),    32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_sys_rst_n = 1'b1;
    cycle();

    // Basic write/read ordering
    push(8'hA5);
    check("w1_count", 32'(o_count),   32'd1);
    check("w1_empty", 32'(o_empty),   32'd0);
    check("w1_data",  32'(o_rd_data), 32'hA5);
    push(8'h3C);
    check("w2_count", 32'(o_count),   32'd2);
    check("w2_data",  32'(o_rd_data), 32'hA5);
    pop();
    check("r1_count", 32'(o_count),   32'd1);
    check("r1_data",  32'(o_rd_data), 32'h3C);
    pop();
    check("r2_count", 32'(o_count),   32'd0);
    check("r2_empty", 32'(o_empty),   32'd1);
    pop();
    check("rempty_count", 32'(o_count), 32'd0);

    // Fill, overflow, drain, clear overrun
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 14) check("fill15_full", 32'(o_full), 32'd0);
      if (i == 15) begin
        check("fill16_full",    32'(o_full),    32'd1);
        check("fill16_overrun", 32'(o_overrun), 32'd0);
      end
    end
    check("ovf_overrun", 32'(o_overrun), 32'd1);
    check("ovf_count",   32'(o_count),   32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_data%0d", i), 32'(o_rd_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(o_empty), 32'd1);
    i_ovr_clr = 1'b1;
    cycle();
    i_ovr_clr = 1'b0;
    check("ovr_clr", 32'(o_overrun), 32'd0);

    // Trigger level
    i_trig_lvl = 2'd2;
    for (int i = 0; i < 7; i++) push(8'(8'h20 + i));
    check("trig_7of8", 32'(o_trig), 32'd0);
    push(8'h27);
    check("trig_8of8", 32'(o_trig), 32'd1);
    i_trig_lvl = 2'd3;
    #1;
    check("trig_8of14", 32'(o_trig), 32'd0);
    i_trig_lvl = 2'd1;
    #1;
    check("trig_8of4", 32'(o_trig), 32'd1);
    pulse_clr();
    i_trig_lvl = 2'd0;
    check("clr_count", 32'(o_count), 32'd0);

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    i_wr_data = 8'h77;
    i_wr_flag = 1'b1;
    i_rd_en   = 1'b1;
    cycle();
    i_wr_flag = 1'b0;
    i_rd_en   = 1'b0;
    check("fullrw_count",   32'(o_count),   32'd16);
    check("fullrw_overrun", 32'(o_overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fullrw_data%0d", i), 32'(o_rd_data), 32'(8'h40 + i));
      pop();
    end
    check("fullrw_last", 32'(o_rd_data), 32'h77);
    pop();
    check("fullrw_empty", 32'(o_empty), 32'd1);

    // Empty with simultaneous write and read
    i_wr_data = 8'h12;
    i_wr_flag = 1'b1;
    i_rd_en   = 1'b1;
    cycle();
    i_wr_flag = 1'b0;
    i_rd_en   = 1'b0;
    check("emptyrw_count", 32'(o_count),   32'd1);
    check("emptyrw_data",  32'(o_rd_data), 32'h12);
    pop();

    // Overrun set wins over clear; FIFO clear leaves overrun alone
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    i_wr_data = 8'h99;
    i_wr_flag = 1'b1;
    i_ovr_clr = 1'b1;
    cycle();
    i_wr_flag = 1'b0;
    i_ovr_clr = 1'b0;
    check("setwins_overrun", 32'(o_overrun), 32'd1);
    check("setwins_data",    32'(o_rd_data), 32'h60);
    pulse_clr();
    check("clr_keeps_ovr",   32'(o_overrun), 32'd1);
    check("clr_full_count",  32'(o_count),   32'd0);
    i_ovr_clr = 1'b1;
    cycle();
    i_ovr_clr = 1'b0;
    check("ovr_clr2", 32'(o_overrun), 32'd0);

    // Clear together with a write
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
    check("five_count", 32'(o_count), 32'd5);
    i_wr_data  = 8'hEE;
    i_wr_flag  = 1'b1;
    i_fifo_clr = 1'b1;
    cycle();
    i_wr_flag  = 1'b0;
    i_fifo_clr = 1'b0;
    check("clrwr_count", 32'(o_count), 32'd0);
    check("clrwr_empty", 32'(o_empty), 32'd1);

    // Character timeout
    push(8'h55);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    for (int k = 1; k <= 99; k++) begin
      cycle();
      if (k == 98) check("to_before", 32'(o_timeout), 32'd0);
    end
    check("to_at99", 32'(o_timeout), 32'd1);
    pop();
    check("to_after_read", 32'(o_timeout), 32'd0);
`else
    for (int k = 1; k <= 150; k++) cycle();
    check("to_disabled", 32'(o_timeout), 32'd0);
    pop();
`endif

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    i_wr_data  = 8'hC3;
    i_wr_flag  = 1'b1;
    i_trig_lvl = 2'd0;
    @(posedge i_sys_clk);
    #2;
    i_sys_rst_n = 1'b0;
    #1;
    check("arst_count",   32'(o_count),   32'd0);
    check("arst_empty",   32'(o_empty),   32'd1);
    check("arst_full",    32'(o_full),    32'd0);
    check("arst_trig",    32'(o_trig),    32'd0);
    check("arst_overrun", 32'(o_overrun), 32'd0);
    check("arst_timeout", 32'(o_timeout), 32'd0);
    i_wr_flag = 1'b0;
    @(negedge i_sys_clk);
    i_sys_rst_n = 1'b1;
    cycle();
    check("post_rst_count", 32'(o_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
